// File: rtl/arm_multicycle_core.sv
// Multicycle ARM subset core: data processing, LDR/STR, B/BL, NZCV conditions and IRQ entry/return.
// A single memory port with a memready wait-state handshake serves instruction fetch and data access.
module arm_multicycle_core #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0018,
  parameter int          ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nIRQ,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] memaddr,
  output logic [3:0]        be,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  input  logic              memready,
  output logic [31:0]       pc,
  output logic [3:0]        flags,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_IRQ = 3'd6
  } state_t;

  state_t      st;
  logic [31:0] rf [15];
  logic [31:0] ir, addr, mdr, sdata;
  logic [3:0]  saved_flags;
  logic        irq_mask;

  wire [3:0] cond = ir[31:28];
  wire [1:0] op   = ir[27:26];
  wire [3:0] cmd  = ir[24:21];
  wire       s_bit = ir[20];
  wire [3:0] rn   = ir[19:16];
  wire [3:0] rd   = ir[15:12];
  wire [3:0] rm   = ir[3:0];

  // R15 always reads as the current instruction address plus 8.
  wire [31:0] rn_val = (rn == 4'd15) ? pc + 32'd8 : rf[rn];
  wire [31:0] rd_val = (rd == 4'd15) ? pc + 32'd8 : rf[rd];
  wire [31:0] rm_val = (rm == 4'd15) ? pc + 32'd8 : rf[rm];

  wire [63:0] rot_tmp  = {24'd0, ir[7:0], 24'd0, ir[7:0]} >> {ir[11:8], 1'b0};
  wire [31:0] src2     = ir[25] ? rot_tmp[31:0] : rm_val;
  wire [31:0] imm12    = {20'd0, ir[11:0]};
  wire [31:0] mem_ea   = ir[23] ? rn_val + imm12 : rn_val - imm12;
  wire [31:0] br_target = pc + 32'd8 + {{6{ir[23]}}, ir[23:0], 2'b00};

  wire is_tst_cmp = (cmd == 4'b1000) || (cmd == 4'b1010);
  wire writes_rd  = !is_tst_cmp;
  wire set_flags  = s_bit || is_tst_cmp;
  wire is_mem     = (op == 2'b01) && !ir[25] && ir[24] && !ir[22] && !ir[21];
  wire is_br      = (op == 2'b10) && ir[25];
  wire is_ldr     = ir[20];

  logic        cond_ok, dp_ok;
  logic [31:0] alu_res;
  logic [32:0] sum;
  logic [3:0]  nzcv;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = flags[2];
      4'h1: cond_ok = !flags[2];
      4'h2: cond_ok = flags[1];
      4'h3: cond_ok = !flags[1];
      4'h4: cond_ok = flags[3];
      4'h5: cond_ok = !flags[3];
      4'h6: cond_ok = flags[0];
      4'h7: cond_ok = !flags[0];
      4'h8: cond_ok = flags[1] && !flags[2];
      4'h9: cond_ok = !flags[1] || flags[2];
      4'hA: cond_ok = flags[3] == flags[0];
      4'hB: cond_ok = flags[3] != flags[0];
      4'hC: cond_ok = !flags[2] && (flags[3] == flags[0]);
      4'hD: cond_ok = flags[2] || (flags[3] != flags[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    sum     = '0;
    nzcv    = flags;
    dp_ok   = 1'b1;
    case (cmd)
      4'b0000, 4'b1000: alu_res = rn_val & src2;
      4'b0001:          alu_res = rn_val ^ src2;
      4'b1100:          alu_res = rn_val | src2;
      4'b1101:          alu_res = src2;
      4'b0100: begin
        sum     = {1'b0, rn_val} + {1'b0, src2};
        alu_res = sum[31:0];
        nzcv[1] = sum[32];
        nzcv[0] = (rn_val[31] == src2[31]) && (alu_res[31] != rn_val[31]);
      end
      4'b0010, 4'b1010: begin
        sum     = {1'b0, rn_val} + {1'b0, ~src2} + 33'd1;
        alu_res = sum[31:0];
        nzcv[1] = sum[32];
        nzcv[0] = (rn_val[31] != src2[31]) && (alu_res[31] != rn_val[31]);
      end
      default: dp_ok = 1'b0;
    endcase
    nzcv[3] = alu_res[31];
    nzcv[2] = (alu_res == 32'd0);
  end

  wire    supported = ((op == 2'b00) && dp_ok) || is_mem || is_br;
  state_t next_tgt;
  assign  next_tgt = (!nIRQ && !irq_mask) ? S_IRQ : S_FETCH;

  // Requests decode only from registered state, so an async reset drops them at once.
  assign memread   = (st == S_FETCH) || ((st == S_MEM) && is_ldr);
  assign memwrite  = (st == S_MEM) && !is_ldr;
  assign memaddr   = (st == S_MEM) ? addr[ADDR_W-1:0] : pc[ADDR_W-1:0];
  assign be        = {4{memread | memwrite}};
  assign writedata = memwrite ? sdata : 32'd0;
  assign state     = st;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= S_RST;
      pc          <= RESET_VECTOR;
      flags       <= 4'd0;
      saved_flags <= 4'd0;
      irq_mask    <= 1'b0;
      ir          <= 32'd0;
      addr        <= 32'd0;
      mdr         <= 32'd0;
      sdata       <= 32'd0;
      // NOTE: the register file is architecturally zero after reset, so this array is reset too.
      for (int i = 0; i < 15; i++) rf[i] <= 32'd0;
    end else begin
      case (st)
        S_RST: st <= S_FETCH;
        S_FETCH: if (memready) begin
          ir <= readdata;
          st <= S_DECODE;
        end
        S_DECODE: if (cond_ok && supported) st <= S_EXEC;
        else begin
          pc <= pc + 32'd4;
          st <= next_tgt;
        end
        S_EXEC: if (is_mem) begin
          addr  <= mem_ea;
          sdata <= rd_val;
          st    <= S_MEM;
        end else if (is_br) begin
          pc <= br_target;
          if (ir[24]) rf[14] <= pc + 32'd4;
          st <= next_tgt;
        end else begin
          if (writes_rd && rd == 4'd15) pc <= alu_res;
          else pc <= pc + 32'd4;
          if (writes_rd && rd != 4'd15) rf[rd] <= alu_res;
          if (s_bit && writes_rd && rd == 4'd15) begin
            flags    <= saved_flags;
            irq_mask <= 1'b0;
          end else if (set_flags) flags <= nzcv;
          st <= next_tgt;
        end
        S_MEM: if (memready) begin
          if (is_ldr) begin
            mdr <= readdata;
            st  <= S_WB;
          end else begin
            pc <= pc + 32'd4;
            st <= next_tgt;
          end
        end
        S_WB: begin
          if (rd == 4'd15) pc <= mdr;
          else begin
            rf[rd] <= mdr;
            pc     <= pc + 32'd4;
          end
          st <= next_tgt;
        end
        S_IRQ: begin
          rf[14]      <= pc + 32'd4;
          saved_flags <= flags;
          irq_mask    <= 1'b1;
          pc          <= IRQ_VECTOR;
          st          <= S_FETCH;
        end
        default: st <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_multicycle_core.sv
// Directed bench for arm_multicycle_core: a small program in a behavioural memory with wait states,
// checked against hand-computed register, flag, bus and per-instruction cycle-count values.
module tb_arm_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        nIRQ = 1'b1;
  logic        memread, memwrite, memready;
  logic [31:0] memaddr, writedata, readdata, pc;
  logic [3:0]  be, flags;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  bit          hold_mem = 1'b0;
  bit          patch_en = 1'b0;
  int          wcnt;
  bit   [31:0] dmem [16];
  int          lat [64];
  int          cyc = 0;
  int          start_cyc = 0;
  logic [31:0] start_pc = 32'd0;
  bit          started = 1'b0;
  logic [2:0]  prev_st = 3'd0;
  int          irq_entries = 0;

  always #5 clk = ~clk;

  arm_multicycle_core dut (
    .clk(clk), .reset(reset), .nIRQ(nIRQ),
    .memread(memread), .memwrite(memwrite), .memaddr(memaddr), .be(be),
    .writedata(writedata), .readdata(readdata), .memready(memready),
    .pc(pc), .flags(flags), .state(state)
  );

  // Program image below 0x100, data words from 0x100; unmapped words decode as never-executed.
  always_comb begin
    readdata = 32'hF000_0000;
    if (memaddr >= 32'h100) readdata = dmem[memaddr[5:2]];
    else if (patch_en && memaddr == 32'h20) readdata = 32'hE1A0F00E; // MOV PC,R14
    else begin
      case (memaddr[7:0])
        8'h00: readdata = 32'hE3A01005; // MOV   R1,#5
        8'h04: readdata = 32'hE2512005; // SUBS  R2,R1,#5
        8'h08: readdata = 32'h12813001; // ADDNE R3,R1,#1
        8'h0C: readdata = 32'h02814002; // ADDEQ R4,R1,#2
        8'h10: readdata = 32'hE3A00C01; // MOV   R0,#0x100
        8'h14: readdata = 32'hEA000000; // B     0x1C
        8'h18: readdata = 32'hE25EF004; // SUBS  PC,R14,#4
        8'h1C: readdata = 32'hE5801004; // STR   R1,[R0,#4]
        8'h20: readdata = 32'hEBFFFFFE; // BL    0x20
        8'h24: readdata = 32'hE5906004; // LDR   R6,[R0,#4]
        8'h28: readdata = 32'hE3510006; // CMP   R1,#6
        8'h2C: readdata = 32'hEA000003; // B     0x40
        8'h40: readdata = 32'hE2818001; // ADD   R8,R1,#1
        8'h44: readdata = 32'hE5808008; // STR   R8,[R0,#8]
        default: ;
      endcase
    end
  end

  // Two wait states on every data transfer; hold_mem stalls a data transfer indefinitely.
  assign memready = !(state == 3'd4 && (hold_mem || wcnt < 2));

  always @(posedge clk or negedge reset) begin
    if (!reset) wcnt <= 0;
    else if (state == 3'd4 && !memready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (reset && memwrite && memready && memaddr >= 32'h100) dmem[memaddr[5:2]] <= writedata;
  end

  // Cycles from one instruction's first FETCH cycle to the next one's, indexed by word address.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      started <= 1'b0;
      prev_st <= 3'd0;
    end else begin
      if (state == 3'd1 && prev_st != 3'd1) begin
        if (started) lat[start_pc[7:2]] <= cyc - start_cyc;
        start_cyc <= cyc;
        start_pc  <= pc;
        started   <= 1'b1;
      end
      if (state == 3'd6 && prev_st != 3'd6) irq_entries <= irq_entries + 1;
      prev_st <= state;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input logic [2:0] st, input logic [31:0] p, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      found = (state == st) && (pc == p);
    end
    check({tag, "_reached"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    // Reset held with memready high.
    repeat (2) @(negedge clk);
    #1;
    check("rst_memread", {31'd0, memread}, 32'd0);
    check("rst_be", {28'd0, be}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    #1;
    check("rel_memread", {31'd0, memread}, 32'd1);
    check("rel_memaddr", memaddr, 32'h0);

    // Flags and conditional execution.
    wait_for(3'd1, 32'h10, "fetch_10");
    check("flags_subs", {28'd0, flags}, 32'h6);
    check("r3_addne", dut.rf[3], 32'd0);
    check("r4_addeq", dut.rf[4], 32'd7);

    // STR with two wait states: request must stay stable.
    wait_for(3'd4, 32'h1C, "str_mem");
    for (int k = 0; k < 3; k++) begin
      check("str_memwrite", {31'd0, memwrite}, 32'd1);
      check("str_memaddr", memaddr, 32'h104);
      check("str_writedata", writedata, 32'd5);
      if (k < 2) begin
        @(negedge clk);
        #1;
      end
    end

    // BL to itself, then replace it with MOV PC,R14.
    wait_for(3'd3, 32'h20, "bl_exec");
    patch_en = 1'b1;
    wait_for(3'd1, 32'h20, "bl_target");
    check("bl_r14", dut.rf[14], 32'h24);
    wait_for(3'd1, 32'h24, "mov_pc_r14");
    check("ret_memread", {31'd0, memread}, 32'd1);
    check("ret_memaddr", memaddr, 32'h24);

    // LDR result.
    wait_for(3'd1, 32'h28, "fetch_28");
    check("ldr_r6", dut.rf[6], 32'd5);
    check("str_dmem", dmem[1], 32'd5);

    // IRQ raised during EXEC of ADD at 0x40, held low through the handler.
    wait_for(3'd3, 32'h40, "add_exec");
    check("flags_cmp", {28'd0, flags}, 32'h8);
    nIRQ = 1'b0;
    @(negedge clk);
    #1;
    check("irq_state", {29'd0, state}, 32'd6);
    wait_for(3'd1, 32'h18, "irq_vector");
    check("irq_r14", dut.rf[14], 32'h48);
    check("irq_mask_set", {31'd0, dut.irq_mask}, 32'd1);
    check("irq_saved_flags", {28'd0, dut.saved_flags}, 32'h8);
    wait_for(3'd1, 32'h44, "irq_return");
    nIRQ = 1'b1;
    check("ret_flags", {28'd0, flags}, 32'h8);
    check("ret_irq_mask", {31'd0, dut.irq_mask}, 32'd0);
    check("irq_entries", irq_entries, 32'd1);
    check("r8_add", dut.rf[8], 32'd6);

    // Per-instruction cycle counts.
    check("lat_mov", lat[0], 32'd3);
    check("lat_subs", lat[1], 32'd3);
    check("lat_addne", lat[2], 32'd2);
    check("lat_addeq", lat[3], 32'd3);
    check("lat_str", lat[7], 32'd6);
    check("lat_ldr", lat[9], 32'd7);
    check("lat_add_irq", lat[16], 32'd4);

    // Reset asserted while a store is stalled.
    hold_mem = 1'b1;
    wait_for(3'd4, 32'h44, "str2_mem");
    check("str2_memwrite", {31'd0, memwrite}, 32'd1);
    check("str2_memaddr", memaddr, 32'h108);
    check("str2_writedata", writedata, 32'd6);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_memwrite", {31'd0, memwrite}, 32'd0);
    check("midrst_be", {28'd0, be}, 32'd0);
    check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    @(negedge clk);
    check("midrst_dmem", dmem[2], 32'd0);
    reset = 1'b1;
    hold_mem = 1'b0;
    #1;
    check("refetch_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    #1;
    check("refetch_memread", {31'd0, memread}, 32'd1);
    check("refetch_memaddr", memaddr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arm_multicycle_core.md
# arm_multicycle_core

Parametrised multicycle successor to the single-cycle ARM processor core. It executes the same ARM data-processing, LDR/STR and B/BL subset over one unified memory port with a wait-state handshake. It adds a persistent NZCV flag register, full 4-bit condition evaluation, and level-sensitive IRQ entry and return. It sits between the top level and a shared instruction/data memory or bus bridge that may stall.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- IRQ_VECTOR, 32'h0000_0018, PC loaded on IRQ entry.
- ADDR_W, 32, memaddr width; must be ≤32, upper PC/address bits are truncated.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- nIRQ  in  1  active-low level interrupt request.
- memread  out  1  read request, for instruction fetch or LDR.
- memwrite  out  1  write request (STR).
- memaddr  out  ADDR_W  byte address.
- be  out  4  byte enables: 4'b1111 while memread or memwrite is high, else 4'b0000.
- writedata  out  32  store data.
- readdata  in  32  read data, valid in the cycle memready=1.
- memready  in  1  transfer completes on the rising edge where the request is high and memready=1.
- pc  out  32  architectural PC, the address of the current instruction.
- flags  out  4  NZCV register.
- state  out  3  FSM state, for debug.

## Operation
- **State encoding:** RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, IRQ=6.
- **Reset values:**
  - state=RST; pc=RESET_VECTOR.
  - R0–R14=0; flags=0; irq_mask=0; saved_flags=0.
  - All request outputs=0; writedata=0.
- **RST:** always advances to FETCH on the next edge.
- **FETCH:**
  - Drives memaddr=pc, memread=1.
  - Waits while memready=0, holding all outputs stable.
  - On memready: IR<=readdata, then DECODE.
- **DECODE:**
  - Reading R15 returns pc+8.
  - Evaluates cond[31:28] against flags with standard ARM EQ..AL semantics; 4'b1111 is treated as never.
  - Condition fails, or opcode unsupported: pc<=pc+4, then goes to the next-instruction target.
  - Otherwise goes to EXEC.
- **EXEC, data processing (op=00):**
  - Supported ops: AND, EOR, SUB, ADD, TST, CMP, ORR, MOV.
  - Operand2 is either imm8 rotated right by 2*rot, or Rm with shift fields ignored.
  - Writes Rd, except for TST and CMP.
  - Flags update when S=1; TST and CMP always update.
    - N and Z come from the result.
    - ADD: C is the carry-out.
    - SUB/CMP: C is NOT borrow.
    - V is signed overflow.
    - Logical ops leave C and V unchanged.
  - Rd=15: pc<=result. With S=1 and Rd=15 (exception return): flags<=saved_flags and irq_mask<=0.
  - Otherwise pc<=pc+4.
  - Then goes to the next-instruction target.
- **EXEC, branch (op=10):**
  - pc<=pc+8+sext(imm24<<2).
  - BL (funct[4]=1): also R14<=pc+4.
  - Then goes to the next-instruction target.
- **EXEC, memory (op=01):**
  - Computes addr=Rn ± imm12 (U=funct[3]).
  - Only the immediate-offset, pre-indexed, no-writeback form is supported; B=1 is treated as unsupported.
  - Then goes to MEM.
- **MEM:**
  - Drives memaddr=addr; STR: memwrite=1, writedata=Rd; LDR: memread=1.
  - Waits for memready.
  - STR: pc<=pc+4, then goes to the next-instruction target.
  - LDR: latches readdata, then WB.
- **WB:**
  - Rd<=data.
  - pc<=data if Rd=15, else pc+4.
  - Then goes to the next-instruction target.
- **Next-instruction target:**
  - IRQ if nIRQ=0 and irq_mask=0, both sampled on that edge.
  - Otherwise FETCH.
- **IRQ:**
  - R14<=pc+4, where pc is already the return address.
  - saved_flags<=flags; irq_mask<=1.
  - pc<=IRQ_VECTOR.
  - Then FETCH.
- **Arithmetic:** all arithmetic is 32-bit modulo 2^32; memaddr = addr[ADDR_W-1:0].
- **Alignment:** memaddr low bits pass through unchanged; alignment is the software's responsibility.
- **nIRQ behaviour:** nIRQ going high before it is sampled means no entry; nIRQ is ignored while irq_mask=1.

## Timing
- Request outputs (memread, memwrite, memaddr, be, writedata) are decoded from registered state and addr, with no path from memready.
- Zero-wait-state latency (memready tied high):
  - Data-processing or branch: 3 cycles (FETCH, DECODE, EXEC).
  - Condition-failed or unsupported: 2 cycles.
  - STR: 4 cycles.
  - LDR: 5 cycles.
  - IRQ entry: +1 cycle.
- Each cycle with memready=0 during FETCH or MEM adds exactly 1 cycle.
- Register, flag and pc updates take effect on the edge that leaves the state.
- Reset asserted mid-transfer: all requests drop immediately (asynchronously) and the pending transfer is abandoned. After release, the first FETCH request is seen 1 cycle later, at RESET_VECTOR.

## Test plan
- **Reset:**
  - Stimulus: hold reset=0 with memready=1.
  - Required, during reset: memread=0, be=0, pc=RESET_VECTOR, state=0.
  - Required, after release: in the first cycle state=0, in the second cycle memread=1 with memaddr=0.
- **Flags and conditions:**
  - Stimulus: program MOV R1,#5; SUBS R2,R1,#5; ADDNE R3,R1,#1; ADDEQ R4,R1,#2.
  - Required: flags=4'b0110, R3 remains 0, R4=7.
  - Required: the ADDNE cycle count is 2 and the others are 3.
- **Load/store with wait states:**
  - Stimulus: memready held low 2 cycles in each MEM; R0=0x100, R1=5; STR R1,[R0,#4]; LDR R6,[R0,#4].
  - Required: memaddr=0x104 and writedata=5, both stable across the waits; R6=5.
  - Required: STR takes 6 cycles and LDR takes 7.
- **Branch and link:**
  - Stimulus: BL with imm24=0xFFFFFE at pc=0x20.
  - Required: pc=0x20 and R14=0x24.
  - Stimulus: a following MOV PC,R14.
  - Required: fetch at 0x24.
- **IRQ entry and return:**
  - Stimulus: nIRQ=0 during EXEC of an ADD at 0x40, flags=4'b1000.
  - Required: IRQ state is entered, then R14=0x48, pc=0x18, irq_mask=1.
  - Required: nIRQ is ignored in the handler.
  - Stimulus: SUBS PC,R14,#4.
  - Required: pc=0x44, flags=4'b1000, irq_mask=0.
- **Reset mid-transfer:**
  - Stimulus: assert reset during a MEM write with memready=0.
  - Required: memwrite falls within the same cycle; no register changes.
  - Required: after release, refetch starts at RESET_VECTOR.
